// File: rtl/muon_sync_pkg.sv
// Shared types and defaults for the muon DAQ input synchronisers.
// Edge-mode encoding and the event gating helper live here.
package muon_sync_pkg;

    typedef enum logic [1:0] {
        EDGE_OFF  = 2'b00,
        EDGE_RISE = 2'b01,
        EDGE_FALL = 2'b10,
        EDGE_BOTH = 2'b11
    } edge_mode_t;

    localparam int SYNC_STAGES_DEF = 2;
    localparam int FILTER_LEN_DEF  = 4;

    function automatic logic gate_event(
        input edge_mode_t mode,
        input logic       rise,
        input logic       fall
    );
        logic ev;
        ev = 1'b0;
        unique case (mode)
            EDGE_OFF:  ev = 1'b0;
            EDGE_RISE: ev = rise;
            EDGE_FALL: ev = fall;
            EDGE_BOTH: ev = rise | fall;
        endcase
        return ev;
    endfunction

endpackage

// File: rtl/edge_sync_channel.sv
// One channel: FF sync chain, stability filter, edge pulses, event gating.
// Optional saturating event counter under MULTI_EDGE_SYNC_COUNT_EN.
module edge_sync_channel
    import muon_sync_pkg::*;
#(
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
`ifdef MULTI_EDGE_SYNC_COUNT_EN
    ,
    parameter int COUNT_W     = 16
`endif
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic               i_signal,
    input  logic [1:0]         i_mode,
    output logic               o_level,
    output logic               o_rise,
    output logic               o_fall,
    output logic               o_event
`ifdef MULTI_EDGE_SYNC_COUNT_EN
    ,
    input  logic               i_cnt_clr,
    output logic [COUNT_W-1:0] o_count
`endif
);

    localparam int FCNT_W = $clog2(FILTER_LEN + 1);
    localparam logic [FCNT_W-1:0] FCNT_MAX = FCNT_W'(FILTER_LEN - 1);

    logic [SYNC_STAGES-1:0] sync_q, sync_d;
    logic [FCNT_W-1:0]      fcnt_q, fcnt_d;
    logic                   level_q, level_d;
    logic                   rise_q, rise_d;
    logic                   fall_q, fall_d;
    logic                   event_q, event_d;
    logic                   s;

    always_comb begin
        sync_d  = {sync_q[SYNC_STAGES-2:0], i_signal};
        s       = sync_q[SYNC_STAGES-1];
        level_d = level_q;
        fcnt_d  = '0;
        // A new level is accepted only after FILTER_LEN consecutive mismatches
        if (s != level_q) begin
            if (fcnt_q == FCNT_MAX) begin
                level_d = s;
            end else begin
                fcnt_d = fcnt_q + 1'b1;
            end
        end
        rise_d  = level_d & ~level_q;
        fall_d  = ~level_d & level_q;
        event_d = gate_event(edge_mode_t'(i_mode), rise_d, fall_d);
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            sync_q  <= '0;
            fcnt_q  <= '0;
            level_q <= 1'b0;
            rise_q  <= 1'b0;
            fall_q  <= 1'b0;
            event_q <= 1'b0;
        end else begin
            sync_q  <= sync_d;
            fcnt_q  <= fcnt_d;
            level_q <= level_d;
            rise_q  <= rise_d;
            fall_q  <= fall_d;
            event_q <= event_d;
        end
    end

    assign o_level = level_q;
    assign o_rise  = rise_q;
    assign o_fall  = fall_q;
    assign o_event = event_q;

`ifdef MULTI_EDGE_SYNC_COUNT_EN
    logic [COUNT_W-1:0] cnt_q, cnt_d;

    // Clear coinciding with an event loads 1 so that event is kept
    always_comb begin
        cnt_d = cnt_q;
        if (i_cnt_clr) begin
            cnt_d = event_q ? COUNT_W'(1) : '0;
        end else if (event_q && (cnt_q != '1)) begin
            cnt_d = cnt_q + 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign o_count = cnt_q;
`endif

endmodule

// File: rtl/multi_edge_sync.sv
// N_CH-channel synchroniser/glitch filter with per-channel edge events.
// Define MULTI_EDGE_SYNC_COUNT_EN to add per-channel saturating counters.
module multi_edge_sync
    import muon_sync_pkg::*;
#(
    parameter int N_CH        = 4,
    parameter int SYNC_STAGES = SYNC_STAGES_DEF,
    parameter int FILTER_LEN  = FILTER_LEN_DEF
`ifdef MULTI_EDGE_SYNC_COUNT_EN
    ,
    parameter int COUNT_W     = 16
`endif
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic [N_CH-1:0]         i_signal,
    input  logic [2*N_CH-1:0]       i_mode,
    output logic [N_CH-1:0]         o_level,
    output logic [N_CH-1:0]         o_rise,
    output logic [N_CH-1:0]         o_fall,
    output logic [N_CH-1:0]         o_event,
    output logic                    o_any_event
`ifdef MULTI_EDGE_SYNC_COUNT_EN
    ,
    input  logic [N_CH-1:0]         i_cnt_clr,
    output logic [COUNT_W*N_CH-1:0] o_count
`endif
);

    logic any_event_q, any_event_d;

    for (genvar g = 0; g < N_CH; g++) begin : g_ch
        edge_sync_channel #(
            .SYNC_STAGES (SYNC_STAGES),
            .FILTER_LEN  (FILTER_LEN)
`ifdef MULTI_EDGE_SYNC_COUNT_EN
            ,
            .COUNT_W     (COUNT_W)
`endif
        ) u_ch (
            .clk       (clk),
            .rst_n     (rst_n),
            .i_signal  (i_signal[g]),
            .i_mode    (i_mode[2*g +: 2]),
            .o_level   (o_level[g]),
            .o_rise    (o_rise[g]),
            .o_fall    (o_fall[g]),
            .o_event   (o_event[g])
`ifdef MULTI_EDGE_SYNC_COUNT_EN
            ,
            .i_cnt_clr (i_cnt_clr[g]),
            .o_count   (o_count[COUNT_W*g +: COUNT_W])
`endif
        );
    end

    always_comb begin
        any_event_d = |o_event;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            any_event_q <= 1'b0;
        end else begin
            any_event_q <= any_event_d;
        end
    end

    assign o_any_event = any_event_q;

endmodule

// File: tb/tb_multi_edge_sync.sv
// Directed scoreboard bench for multi_edge_sync (4 channels, 2 sync, filter 4).
module tb_multi_edge_sync;

    localparam int LAT = 6;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  i_signal;
    logic [7:0]  i_mode;
    logic [3:0]  o_level, o_rise, o_fall, o_event;
    logic        o_any_event;
`ifdef MULTI_EDGE_SYNC_COUNT_EN
    logic [3:0]  i_cnt_clr;
    logic [15:0] o_count;
`endif

    multi_edge_sync #(
        .N_CH        (4),
        .SYNC_STAGES (2),
        .FILTER_LEN  (4)
`ifdef MULTI_EDGE_SYNC_COUNT_EN
        ,
        .COUNT_W     (4)
`endif
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .i_signal    (i_signal),
        .i_mode      (i_mode),
        .o_level     (o_level),
        .o_rise      (o_rise),
        .o_fall      (o_fall),
        .o_event     (o_event),
        .o_any_event (o_any_event)
`ifdef MULTI_EDGE_SYNC_COUNT_EN
        ,
        .i_cnt_clr   (i_cnt_clr),
        .o_count     (o_count)
`endif
    );

    always #5 clk = ~clk;

    int unsigned edges = 0;
    always @(posedge clk) edges <= edges + 1;

    typedef struct {
        int unsigned cyc;
        int          kind;
        logic [31:0] exp;
        string       tag;
    } exp_t;

    exp_t q[$];
    int n_assert = 0;
    int n_fail   = 0;
    logic [3:0] ren, fen, cur;

    task automatic push(input int unsigned cyc, input int kind,
                        input logic [31:0] exp, input string tag);
        exp_t e;
        e.cyc = cyc; e.kind = kind; e.exp = exp; e.tag = tag;
        q.push_back(e);
    endtask

    task automatic check_due();
        int i;
        logic [31:0] obs;
        i = 0;
        while (i < q.size()) begin
            if (q[i].cyc <= edges) begin
                obs = {15'b0, o_level, o_rise, o_fall, o_event, o_any_event};
`ifdef MULTI_EDGE_SYNC_COUNT_EN
                if (q[i].kind == 1) obs = {28'b0, o_count[3:0]};
`endif
                if (q[i].cyc < edges) obs = 32'hDEAD_BEEF;
                n_assert++;
                assert (obs === q[i].exp) else begin
                    n_fail++;
                    $error("FAIL %s @%0d: observed %h expected %h",
                           q[i].tag, q[i].cyc, obs, q[i].exp);
                end
                q.delete(i);
            end else begin
                i++;
            end
        end
    endtask

    task automatic tick(input int n);
        for (int k = 0; k < n; k++) begin
            @(negedge clk);
            check_due();
        end
    endtask

    task automatic set_mode(input logic [7:0] m);
        i_mode = m;
        for (int c = 0; c < 4; c++) begin
            ren[c] = m[2*c];
            fen[c] = m[2*c+1];
        end
    endtask

    task automatic expect_quiet(input int unsigned a, input int unsigned b,
                                input logic [3:0] lv, input string tag);
        for (int unsigned c = a; c <= b; c++)
            push(c, 0, {15'b0, lv, 13'b0}, tag);
    endtask

    task automatic expect_change(input int unsigned t0, input logic [3:0] lo,
                                 input logic [3:0] ln, input string tag);
        logic [3:0] r, f, e;
        r = ln & ~lo;
        f = lo & ~ln;
        e = (r & ren) | (f & fen);
        push(t0 + LAT - 1, 0, {15'b0, lo, 13'b0}, {tag, "_pre"});
        push(t0 + LAT, 0, {15'b0, ln, r, f, e, 1'b0}, {tag, "_edge"});
        push(t0 + LAT + 1, 0, {15'b0, ln, 12'b0, |e}, {tag, "_any"});
        push(t0 + LAT + 2, 0, {15'b0, ln, 13'b0}, {tag, "_post"});
    endtask

    task automatic drive(input logic [3:0] v, input string tag);
        expect_change(edges, cur, v, tag);
        i_signal = v;
        cur = v;
        tick(LAT + 3);
    endtask

    initial begin
        int unsigned t;
        rst_n = 1'b0;
        i_signal = 4'hF;
        cur = 4'h0;
        set_mode(8'hFF);
`ifdef MULTI_EDGE_SYNC_COUNT_EN
        i_cnt_clr = 4'h0;
`endif
        expect_quiet(1, 3, 4'h0, "in_reset");
        tick(3);

        t = edges;
        rst_n = 1'b1;
        expect_quiet(t + 1, t + 4, 4'h0, "release_hold");
        expect_change(t, 4'h0, 4'hF, "release_rise");
        cur = 4'hF;
        tick(LAT + 3);
        drive(4'h0, "all_fall");

        t = edges;
        i_signal = 4'h1;
        expect_quiet(t + 1, t + 12, 4'h0, "glitch3");
        tick(3);
        i_signal = 4'h0;
        tick(12);

        t = edges;
        expect_change(t, 4'h0, 4'h1, "pulse4_rise");
        expect_change(t + 4, 4'h1, 4'h0, "pulse4_fall");
        i_signal = 4'h1;
        tick(4);
        i_signal = 4'h0;
        tick(LAT + 3);

        set_mode(8'b11_10_01_00);
        tick(2);
        drive(4'hF, "mode_rise");
        drive(4'h0, "mode_fall");

        set_mode(8'hFF);
        tick(2);
        drive(4'b0100, "ch2_up");
        drive(4'b0001, "simul");
        drive(4'b0000, "simul_clr");

        t = edges;
        i_signal = 4'b0010;
        expect_quiet(t + 1, t + 9, 4'h0, "rst_mid");
        tick(4);
        rst_n = 1'b0;
        tick(1);
        rst_n = 1'b1;
        expect_change(t + 5, 4'h0, 4'b0010, "rst_mid_rise");
        cur = 4'b0010;
        tick(LAT + 3);
        drive(4'h0, "rst_mid_fall");

`ifdef MULTI_EDGE_SYNC_COUNT_EN
        set_mode(8'b11_11_11_01);
        tick(2);
        t = edges;
        i_cnt_clr = 4'b0001;
        push(t + 1, 1, 32'd0, "clr_alone");
        tick(1);
        i_cnt_clr = 4'b0000;
        tick(2);
        for (int k = 0; k < 17; k++) begin
            t = edges;
            push(t + 16, 1, (k + 1 > 15) ? 32'd15 : 32'(k + 1), "cnt_sat");
            i_signal = 4'h1;
            tick(8);
            i_signal = 4'h0;
            tick(8);
        end
        t = edges;
        i_signal = 4'h1;
        tick(LAT);
        i_cnt_clr = 4'b0001;
        push(t + LAT + 1, 1, 32'd1, "clr_with_event");
        tick(1);
        i_cnt_clr = 4'b0000;
        push(t + LAT + 4, 1, 32'd1, "clr_with_event_hold");
        tick(4);
        i_signal = 4'h0;
        tick(10);
`endif

        n_assert++;
        assert (q.size() == 0) else begin
            n_fail++;
            $error("FAIL leftover: observed %0d expected 0", q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_assert, n_fail);
        $finish;
    end

endmodule

// File: doc/multi_edge_sync.md
Name: multi_edge_sync

Overview:
- Parametrised successor to the single-bit 2-FF synchroniser used on discriminator and trigger inputs.
- Synchronises N_CH asynchronous channels through a configurable FF chain and rejects glitches with a per-channel stability filter.
- Emits registered one-cycle rise/fall/event pulses per channel, with a runtime-selectable edge mode per channel.
- Sits between the FPGA input pins (SiPM discriminator outputs) and the coincidence/timestamp logic of the muon DAQ.

Parameters:
- N_CH, 4, number of independent channels (>=1).
- SYNC_STAGES, 2, synchroniser FF depth (>=2).
- FILTER_LEN, 4, consecutive cycles a new level must persist before acceptance (>=1).
- COUNT_W, 16, per-channel event counter width (used only with the optional feature).

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset, synchronous, active-low
- i_signal  in  N_CH  asynchronous channel inputs
- i_mode  in  2*N_CH  per-channel edge mode, 2 bits each: 00 off, 01 rise, 10 fall, 11 both
- o_level  out  N_CH  synchronised, filtered level
- o_rise  out  N_CH  1-cycle pulse on accepted 0->1
- o_fall  out  N_CH  1-cycle pulse on accepted 1->0
- o_event  out  N_CH  o_rise/o_fall gated by i_mode
- o_any_event  out  1  registered OR of all o_event bits of the same cycle
- i_cnt_clr  in  N_CH  counter clear (optional feature only)
- o_count  out  COUNT_W*N_CH  per-channel event counts (optional feature only)

Behaviour:
- Reset: while rst_n=0 at a clk edge, clear all sync FFs, filter counters, o_level, o_rise, o_fall, o_event, o_any_event and o_count to 0.
- Sync chain: i_signal shifts through SYNC_STAGES FFs per channel; the last stage (s) drives the filter.
- Filter, per channel, with counter fcnt:
  - s == o_level: fcnt <= 0.
  - s != o_level and fcnt == FILTER_LEN-1: o_level <= s, fcnt <= 0.
  - Otherwise: fcnt <= fcnt+1.
  - Width of fcnt is $clog2(FILTER_LEN+1).
- Latency: a stable input change shows on o_level exactly SYNC_STAGES+FILTER_LEN clk edges after the first sampling edge.
- Glitch rejection: a mismatch shorter than FILTER_LEN cycles at s never changes o_level and produces no pulse.
- Pulses: o_rise/o_fall are asserted in the same cycle o_level changes and for exactly one cycle. Minimum spacing between pulses on one channel is FILTER_LEN cycles.
- o_event is registered at the same edge as o_rise/o_fall, using the i_mode value sampled at that edge.
  - A mode change takes effect for edges accepted on the following edge onward.
  - Mode 00 never pulses.
- o_any_event lags o_event by one cycle.
- Channels are fully independent. Simultaneous edges on several channels each pulse in the same cycle.
- Reset mid-operation: the filter state is lost and o_level returns to 0. If an input is held high through reset release, a rise is reported SYNC_STAGES+FILTER_LEN edges after release. This is intended.
- No combinational path from any input to any output.

Optional Feature:
- Macro: MULTI_EDGE_SYNC_COUNT_EN.
- Defined:
  - Per-channel COUNT_W-bit counter increments on o_event and saturates at all-ones.
  - i_cnt_clr is synchronous; with simultaneous clear and event the counter loads 1, so the event is not lost.
  - o_count is registered, and the counter value updates one cycle after the event pulse.
- Undefined:
  - i_cnt_clr and o_count are absent from the port list.
  - No counter logic is present.

Decomposition:
- Package muon_sync_pkg:
  - edge_mode_t enum (EDGE_OFF, EDGE_RISE, EDGE_FALL, EDGE_BOTH).
  - Default constants SYNC_STAGES_DEF=2, FILTER_LEN_DEF=4.
- Sub-module edge_sync_channel: single channel covering sync chain, filter, pulse generation and optional counter.
- multi_edge_sync instantiates N_CH copies in a generate loop and adds the o_any_event register.

Test Plan:
- Reset/defaults: hold rst_n=0 with i_signal=4'hF, then release. Outputs stay 0 for 5 edges. On the 6th edge o_level=4'hF and o_rise=4'hF for 1 cycle.
- Glitch rejection: defaults, ch0 high for 3 clk cycles. No o_level change and no pulses. Repeat with 4 cycles: o_rise[0]=1 once, o_level[0]=1 then 0, o_fall[0]=1 once.
- Mode gating: i_mode=8'b11_10_01_00, toggle all channels high then low.
  - o_event[0] never pulses.
  - ch1 pulses on rise only; ch2 on fall only; ch3 on both.
  - o_any_event follows one cycle later.
- Simultaneous/independent: ch0 rises while ch2 falls in the same cycle. Both pulses appear in the same cycle with no cross-channel interference.
- Reset mid-filter: ch1 high for 2 filter cycles, then rst_n=0 for 1 cycle, then input held high. Rise is reported 6 edges after release, with no earlier pulse.
- MULTI_EDGE_SYNC_COUNT_EN, COUNT_W=4:
  - 17 rises on ch0 give o_count[0]=15 (saturated).
  - i_cnt_clr coincident with an event gives 1.
  - i_cnt_clr alone gives 0.
